hash_bucket_counter: RTL and testbench

//  Downstream consumer of the hash-key FIFO. Pops one 16-bit hash key per cycle and increments a
//  per-bucket occupancy counter held in on-chip dual-port RAM. The host reads bucket counts through
//  a query port and zeroes the table with a clear sweep. Produces the histogram used by the readout logic.

---
 rtl/hash_bucket_counter_pkg.sv | 17 +
 rtl/hash_bucket_counter_ram.sv | 34 +++
 rtl/hash_bucket_counter.sv | 149 ++++++++++++++
 tb/tb_hash_bucket_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_bucket_counter_pkg.sv
// Shared definitions for the hash bucket histogram block.
//   - Default widths for key, bucket index, per-bucket counter and total counter.
//   - Controller state encoding: CLEAR (table sweep), RUN (counting), DRAIN (flush pipeline).
package hash_bucket_counter_pkg;

  localparam int KEY_WIDTH_DEF   = 16;
  localparam int INDEX_BITS_DEF  = 8;
  localparam int COUNT_WIDTH_DEF = 16;
  localparam int TOTAL_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/hash_bucket_counter_ram.sv
// Bucket counter storage, 2**ADDR_BITS x DATA_WIDTH.
//   Port A : one synchronous write and one synchronous read per cycle, read-first
//            (a read of the address being written returns the old contents).
//   Port B : synchronous read-only port for host queries, also read-first.
// Ports:
//   clk                 clock
//   a_we/a_waddr/a_wdata port A write
//   a_raddr/a_rdata     port A read (data one cycle after address)
//   b_addr/b_rdata      port B read (data one cycle after address)
module hash_bucket_counter_ram #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  a_we,
  input  logic [ADDR_BITS-1:0]  a_waddr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [ADDR_BITS-1:0]  a_raddr,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic [ADDR_BITS-1:0]  b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: the array has no reset so it maps onto block RAM; the controller's
  // clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_waddr] <= a_wdata;
    a_rdata <= mem[a_raddr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/hash_bucket_counter.sv
// Per-bucket hash key histogram.
// Pops one key per cycle from the upstream FIFO, increments the saturating counter of
// bucket key[INDEX_BITS-1:0] through a 2-stage read-modify-write pipeline, and serves host
// queries on a second RAM port. A clear request drains the pipeline and sweeps the table to 0.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   in_valid/in_hash_key FIFO head; in_pop advances it (combinational)
//   clear_start          one-cycle request for a full-table clear (honoured in RUN only)
//   q_req/q_idx          query strobe and bucket; q_valid/q_count answer one cycle later
//   busy                 high while clearing or draining
//   sat_flag             sticky: some bucket saturated since last clear
//   total_count          keys accepted since last clear (wraps)
module hash_bucket_counter
  import hash_bucket_counter_pkg::*;
#(
  parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
  parameter int INDEX_BITS  = INDEX_BITS_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int TOTAL_WIDTH = TOTAL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [KEY_WIDTH-1:0]   in_hash_key,
  output logic                   in_pop,
  input  logic                   clear_start,
  input  logic                   q_req,
  input  logic [INDEX_BITS-1:0]  q_idx,
  output logic                   q_valid,
  output logic [COUNT_WIDTH-1:0] q_count,
  output logic                   busy,
  output logic                   sat_flag,
  output logic [TOTAL_WIDTH-1:0] total_count
);

  state_t                  state;
  logic [INDEX_BITS-1:0]   clr_idx;
  logic                    accept;
  logic [INDEX_BITS-1:0]   idx;
  logic                    unused_key_bits;

  // S1: key accepted last cycle, RAM read in flight. W: value written last cycle.
  logic                    s1_valid;
  logic [INDEX_BITS-1:0]   s1_idx;
  logic                    w_valid;
  logic [INDEX_BITS-1:0]   w_idx;
  logic [COUNT_WIDTH-1:0]  w_data;

  logic [COUNT_WIDTH-1:0]  rd_raw;
  logic [COUNT_WIDTH-1:0]  rd;
  logic [COUNT_WIDTH-1:0]  nv;
  logic                    at_max;
  logic                    ram_we;
  logic [INDEX_BITS-1:0]   ram_waddr;
  logic [COUNT_WIDTH-1:0]  ram_wdata;
  logic [COUNT_WIDTH-1:0]  b_rdata;

  assign idx             = in_hash_key[INDEX_BITS-1:0];
  assign unused_key_bits = ^in_hash_key[KEY_WIDTH-1:INDEX_BITS];

  // rstn gates acceptance directly so nothing is popped while reset is held,
  // even before the first reset edge has forced the state back to CLEAR.
  assign accept  = rstn & in_valid & (state == ST_RUN);
  assign in_pop  = accept;
  assign busy    = ~rstn | (state != ST_RUN);
  assign q_count = q_valid ? b_rdata : '0;

  // The RAM is read-first, so a read issued in the same cycle as the write to the
  // same bucket returns stale data; W holds that just-written value and overrides it.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    rd = rd_raw;
    if (w_valid && (w_idx == s1_idx)) rd = w_data;
    at_max    = &rd;
    nv        = at_max ? rd : rd + COUNT_WIDTH'(1);
    ram_we    = 1'b0;
    ram_waddr = s1_idx;
    ram_wdata = nv;
    if (rstn) begin
      if (state == ST_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx;
        ram_wdata = '0;
      end else if (s1_valid) begin
        ram_we = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_CLEAR;
      clr_idx     <= '0;
      s1_valid    <= 1'b0;
      w_valid     <= 1'b0;
      q_valid     <= 1'b0;
      sat_flag    <= 1'b0;
      total_count <= '0;
    end else begin
      s1_valid <= accept;
      w_valid  <= s1_valid;
      q_valid  <= q_req;
      if (accept) total_count <= total_count + TOTAL_WIDTH'(1);
      if (s1_valid && at_max) sat_flag <= 1'b1;
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + INDEX_BITS'(1);
          if (&clr_idx) state <= ST_RUN;
        end
        ST_RUN: begin
          if (clear_start) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Once S1 is empty its write has committed; W only feeds the bypass.
          if (!s1_valid) begin
            state       <= ST_CLEAR;
            total_count <= '0;
            sat_flag    <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Pure datapath registers: qualified by the valids above, so no reset needed.
  always_ff @(posedge clk) begin
    s1_idx <= idx;
    w_idx  <= s1_idx;
    w_data <= nv;
  end

  hash_bucket_counter_ram #(
    .ADDR_BITS  (INDEX_BITS),
    .DATA_WIDTH (COUNT_WIDTH)
  ) u_ram (
    .clk     (clk),
    .a_we    (ram_we),
    .a_waddr (ram_waddr),
    .a_wdata (ram_wdata),
    .a_raddr (idx),
    .a_rdata (rd_raw),
    .b_addr  (q_idx),
    .b_rdata (b_rdata)
  );

endmodule

// File: tb/tb_hash_bucket_counter.sv
// Scoreboard bench for hash_bucket_counter: a 16-bit-counter instance for the main
// scenarios and a 4-bit-counter instance for saturation. Queries push their expected
// count into a queue; a monitor per instance pops and compares whenever q_valid is seen.
module tb_hash_bucket_counter;

  logic        clk;
  logic        rstn;

  logic        in_valid, in_pop, clear_start, q_req, q_valid, busy, sat_flag;
  logic [15:0] in_hash_key, q_count;
  logic [7:0]  q_idx;
  logic [31:0] total_count;

  logic        in_valid4, in_pop4, clear_start4, q_req4, q_valid4, busy4, sat_flag4;
  logic [15:0] in_hash_key4;
  logic [3:0]  q_count4;
  logic [7:0]  q_idx4;
  logic [31:0] total_count4;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] exp_val[$];
  string       exp_name[$];
  logic [15:0] exp_val4[$];
  string       exp_name4[$];
  logic [15:0] mon_exp, mon_exp4;
  string       mon_name, mon_name4;

  hash_bucket_counter dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_hash_key(in_hash_key), .in_pop(in_pop),
    .clear_start(clear_start), .q_req(q_req), .q_idx(q_idx), .q_valid(q_valid),
    .q_count(q_count), .busy(busy), .sat_flag(sat_flag), .total_count(total_count)
  );

  hash_bucket_counter #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_hash_key(in_hash_key4), .in_pop(in_pop4),
    .clear_start(clear_start4), .q_req(q_req4), .q_idx(q_idx4), .q_valid(q_valid4),
    .q_count(q_count4), .busy(busy4), .sat_flag(sat_flag4), .total_count(total_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [15:0] k, input string name);
    in_valid    = 1'b1;
    in_hash_key = k;
    @(negedge clk);
    check(name, in_pop, 1);
    tick();
  endtask

  task automatic query(input logic [7:0] idx, input logic [15:0] e);
    q_req = 1'b1;
    q_idx = idx;
    exp_val.push_back(e);
    exp_name.push_back($sformatf("q_idx%0d", idx));
    tick();
    q_req = 1'b0;
  endtask

  task automatic query4(input logic [7:0] idx, input logic [15:0] e);
    q_req4 = 1'b1;
    q_idx4 = idx;
    exp_val4.push_back(e);
    exp_name4.push_back($sformatf("q4_idx%0d", idx));
    tick();
    q_req4 = 1'b0;
  endtask

  // Counts busy cycles on the main instance starting at the next falling edge; returns
  // at the first falling edge where busy is low, leaving inputs untouched.
  task automatic wait_idle(input string name, input int exp_busy);
    int cnt   = 0;
    int pops  = 0;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 2000) begin
      cnt++;
      if (in_pop) pops++;
      guard++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, cnt, exp_busy);
    check({name, "_pop_while_busy"}, pops, 0);
  endtask

  always @(negedge clk) begin
    if (q_valid) begin
      if (exp_val.size() == 0) begin
        check("unexpected_q_valid", 1, 0);
      end else begin
        mon_exp  = exp_val.pop_front();
        mon_name = exp_name.pop_front();
        check(mon_name, q_count, mon_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (q_valid4) begin
      if (exp_val4.size() == 0) begin
        check("unexpected_q_valid4", 1, 0);
      end else begin
        mon_exp4  = exp_val4.pop_front();
        mon_name4 = exp_name4.pop_front();
        check(mon_name4, q_count4, {12'd0, mon_exp4[3:0]});
      end
    end
  end

  initial begin
    rstn = 1'b0;
    in_valid = 1'b1; in_hash_key = 16'h00AA; clear_start = 1'b0; q_req = 1'b0; q_idx = '0;
    in_valid4 = 1'b0; in_hash_key4 = '0; clear_start4 = 1'b0; q_req4 = 1'b0; q_idx4 = '0;

    // Reset held with the FIFO presenting data: nothing may be popped.
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_in_pop", in_pop, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_count", q_count, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_total", total_count, 0);
    tick();
    rstn = 1'b1;

    // Initial sweep: 256 busy cycles, then the table reads back all zero.
    wait_idle("init_sweep", 256);
    check("init_run_pop", in_pop, 1);
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) query(8'(i), 16'd0);

    // Three keys to bucket 3 back-to-back (exercises the write bypass).
    push_key(16'h0003, "t2_pop0");
    push_key(16'h1203, "t2_pop1");
    push_key(16'h0003, "t2_pop2");
    in_valid = 1'b0;
    tick(); tick();
    query(8'd3, 16'd3);
    @(negedge clk);
    check("t2_total", total_count, 3);
    tick();

    // Alternating buckets 5 and 7 for 10 cycles.
    for (int i = 0; i < 10; i++) push_key((i % 2 == 0) ? 16'h0005 : 16'h0007, "t3_pop");
    in_valid = 1'b0;
    tick(); tick();
    query(8'd5, 16'd5);
    query(8'd7, 16'd5);
    query(8'd3, 16'd3);
    @(negedge clk);
    check("t3_total", total_count, 13);
    check("t3_no_sat", sat_flag, 0);
    tick();

    // 4-bit counters: 20 keys to bucket 1 saturate at 15.
    in_valid4 = 1'b1;
    in_hash_key4 = 16'h0001;
    repeat (20) tick();
    in_valid4 = 1'b0;
    tick(); tick();
    query4(8'd1, 16'd15);
    @(negedge clk);
    check("t4_sat_flag", sat_flag4, 1);
    check("t4_total", total_count4, 20);
    tick();
    clear_start4 = 1'b1;
    tick();
    clear_start4 = 1'b0;
    for (int g = 0; g < 2000 && busy4; g++) tick();
    @(negedge clk);
    check("t4_clear_done", busy4, 0);
    check("t4_clear_sat", sat_flag4, 0);
    check("t4_clear_total", total_count4, 0);
    tick();
    query4(8'd1, 16'd0);

    // Clear request during a continuous stream: 2 drain + 256 sweep cycles, no pops.
    in_valid = 1'b1;
    in_hash_key = 16'h0010;
    repeat (3) tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    wait_idle("t5_clear", 258);
    check("t5_stream_resumes", in_pop, 1);
    check("t5_total", total_count, 0);
    check("t5_sat", sat_flag, 0);
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) query(8'(i), 16'd0);

    // Query racing the 4->5 write of bucket 9 returns the pre-write value.
    for (int i = 0; i < 5; i++) push_key(16'h0009, "t6_pop");
    in_valid = 1'b0;
    q_req = 1'b1;
    q_idx = 8'd9;
    exp_val.push_back(16'd4);
    exp_name.push_back("t6_race_pre_write");
    tick();
    query(8'd9, 16'd5);

    // Reset pulse in the middle of a stream discards it and restarts the sweep.
    in_valid = 1'b1;
    in_hash_key = 16'h0009;
    repeat (3) tick();
    rstn = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", busy, 1);
    check("t6_rst_pop", in_pop, 0);
    tick(); tick();
    rstn = 1'b1;
    wait_idle("t6_resweep", 256);
    check("t6_rst_total", total_count, 0);
    in_valid = 1'b0;
    tick();
    query(8'd9, 16'd0);
    query(8'd5, 16'd0);

    repeat (3) tick();
    check("scoreboard_drained", exp_val.size(), 0);
    check("scoreboard4_drained", exp_val4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
